// File: rtl/mmapper_pkg.sv
// Shared types and helpers for the mmapper_router address mapper.
// Optional error log is enabled by defining MMAPPER_ERRLOG_EN (see mmapper_router.sv).
package mmapper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam logic [31:0] ERR_DATA = 32'hdeadbeef;

   // Width of a slave index; a single slave still needs one bit.
   function automatic int sel_width(input int nslv);
      return (nslv <= 1) ? 1 : $clog2(nslv);
   endfunction

   // Watchdog counter width; a disabled watchdog keeps a minimal 1-bit counter.
   function automatic int tmo_width(input int tmo_cycles);
      return (tmo_cycles <= 0) ? 1 : $clog2(tmo_cycles + 1);
   endfunction

endpackage

// File: rtl/mmapper_decode.sv
// Combinational BASE/MASK window match with a lowest-index-wins priority encoder.
module mmapper_decode
   import mmapper_pkg::*;
#(
   parameter int                 NSLV = 8,
   parameter logic [NSLV*32-1:0] BASE = {NSLV{32'h0}},
   parameter logic [NSLV*32-1:0] MASK = {NSLV{32'h0}}
) (
   input  logic [31:0]                addr_i,
   output logic                       hit_o,
   output logic [sel_width(NSLV)-1:0] sel_o
);

   localparam int SW = sel_width(NSLV);

   // Scan downwards so the lowest matching index is the last one written.
   always_comb begin
      hit_o = 1'b0;
      sel_o = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((addr_i & MASK[32*i +: 32]) == (BASE[32*i +: 32] & MASK[32*i +: 32])) begin
            hit_o = 1'b1;
            sel_o = SW'(i);
         end
      end
   end

endmodule

// File: rtl/mmapper_router.sv
// Registered master-to-slave router: window decode, one-hot strobes, access watchdog and bus-error pulse.
// Define MMAPPER_ERRLOG_EN to add the sticky first-error address log (err_addr/err_vld/err_clr).
module mmapper_router
   import mmapper_pkg::*;
#(
   parameter int                 NSLV       = 8,
   parameter logic [NSLV*32-1:0] BASE       = {NSLV{32'h0}},
   parameter logic [NSLV*32-1:0] MASK       = {NSLV{32'h0}},
   parameter int                 TMO_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          a,
   input  logic [31:0]          d,
   input  logic                 we,
   input  logic                 rd,
   output logic [31:0]          spo,
   output logic                 ready,
   output logic                 irq,
   output logic [NSLV*32-1:0]   s_a,
   output logic [NSLV*32-1:0]   s_d,
   output logic [NSLV-1:0]      s_we,
   output logic [NSLV-1:0]      s_rd,
   input  logic [NSLV*32-1:0]   s_spo,
   input  logic [NSLV-1:0]      s_ready
`ifdef MMAPPER_ERRLOG_EN
   ,
   output logic [31:0]          err_addr,
   output logic                 err_vld,
   input  logic                 err_clr
`endif
);

   localparam int SW = sel_width(NSLV);
   localparam int TW = tmo_width(TMO_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = (TMO_CYCLES > 0) ? TW'(TMO_CYCLES - 1) : '0;

   state_e              state_q;
   logic [SW-1:0]       sel_q;
   logic                we_q;
   logic [TW-1:0]       cnt_q;
   logic [31:0]         spo_q;
   logic                ready_q;
   logic                irq_q;
   logic [NSLV*32-1:0]  s_a_q;
   logic [NSLV*32-1:0]  s_d_q;
   logic [NSLV-1:0]     s_we_q;
   logic [NSLV-1:0]     s_rd_q;

   logic                dec_hit;
   logic [SW-1:0]       dec_sel;
   logic [NSLV-1:0]     dec_onehot;
   logic [31:0]         slv_spo;
   logic                slv_ready;
   logic                tmo_hit;

   mmapper_decode #(
      .NSLV (NSLV),
      .BASE (BASE),
      .MASK (MASK)
   ) u_decode (
      .addr_i (a),
      .hit_o  (dec_hit),
      .sel_o  (dec_sel)
   );

   always_comb begin
      dec_onehot = '0;
      slv_spo    = '0;
      slv_ready  = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         if (dec_sel == SW'(i)) dec_onehot[i] = 1'b1;
         if (sel_q == SW'(i)) begin
            slv_spo   = s_spo[32*i +: 32];
            slv_ready = s_ready[i];
         end
      end
   end

   // A zero TMO_CYCLES never matches, so the watchdog stays silent.
   assign tmo_hit = (TMO_CYCLES != 0) && (cnt_q == TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         spo_q   <= '0;
         ready_q <= 1'b0;
         irq_q   <= 1'b0;
         s_a_q   <= '0;
         s_d_q   <= '0;
         s_we_q  <= '0;
         s_rd_q  <= '0;
      end else begin
         ready_q <= 1'b0;
         irq_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rd || we) begin
                  sel_q <= dec_sel;
                  we_q  <= we;
                  cnt_q <= '0;
                  if (dec_hit) begin
                     for (int i = 0; i < NSLV; i++) begin
                        if (dec_onehot[i]) begin
                           s_a_q[32*i +: 32] <= a;
                           s_d_q[32*i +: 32] <= d;
                        end
                     end
                     s_we_q  <= we ? dec_onehot : '0;
                     s_rd_q  <= we ? '0 : dec_onehot;
                     state_q <= ST_ACCESS;
                  end else begin
                     spo_q   <= ERR_DATA;
                     ready_q <= 1'b1;
                     irq_q   <= 1'b1;
                     state_q <= ST_RESP;
                  end
               end
            end
            ST_ACCESS: begin
               // Slave ready takes precedence over a timeout in the same cycle.
               if (slv_ready) begin
                  spo_q   <= we_q ? 32'h0 : slv_spo;
                  s_we_q  <= '0;
                  s_rd_q  <= '0;
                  ready_q <= 1'b1;
                  state_q <= ST_RESP;
               end else if (tmo_hit) begin
                  spo_q   <= ERR_DATA;
                  s_we_q  <= '0;
                  s_rd_q  <= '0;
                  ready_q <= 1'b1;
                  irq_q   <= 1'b1;
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + TW'(1);
               end
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign spo   = spo_q;
   assign ready = ready_q;
   assign irq   = irq_q;
   assign s_a   = s_a_q;
   assign s_d   = s_d_q;
   assign s_we  = s_we_q;
   assign s_rd  = s_rd_q;

`ifdef MMAPPER_ERRLOG_EN
   logic [31:0] req_a_q;
   logic [31:0] err_addr_q;
   logic        err_vld_q;

   // Request address kept for the log, since unmapped accesses never reach s_a.
   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && (rd || we)) req_a_q <= a;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_addr_q <= '0;
         err_vld_q  <= 1'b0;
      end else if (err_clr) begin
         err_vld_q <= 1'b0;
      end else if (irq_q && !err_vld_q) begin
         err_addr_q <= req_a_q;
         err_vld_q  <= 1'b1;
      end
   end

   assign err_addr = err_addr_q;
   assign err_vld  = err_vld_q;
`endif

endmodule
